// File: rtl/sram_fifo_pkg.sv
// Shared sizing constants and pointer helper for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

   localparam int DATA_W       = 16;
   localparam int ADDR_W       = 4;
   localparam int DEPTH        = 16;          // must equal 2**ADDR_W
   localparam int AFULL_THRESH = 12;
   localparam int CNT_W        = ADDR_W + 1;  // holds 0..DEPTH

   // Advance an SRAM address by one, wrapping DEPTH-1 back to 0.
   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Stream interface of the SRAM FIFO controller: write stream in, read stream out.
//
// Handshake: a word moves on a rising edge where valid & ready are both high.
// valid, once raised, holds together with its data until the transfer
// happens; ready may change freely and never depends on valid from the same side.
interface sram_fifo_ctrl_if;
   import sram_fifo_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;

   // FIFO side: accepts the write stream, sources the read stream.
   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data
   );

   // Producer/consumer side.
   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data
   );

endinterface

// File: rtl/sram_fifo_ptr.sv
// Wrapping ADDR_W-bit SRAM pointer with increment enable.
module sram_fifo_ptr
   import sram_fifo_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] ptr_o
);

   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;

   // Next pointer: step with wrap when enabled, otherwise hold.
   always_comb begin
      ptr_d = inc_i ? ptr_inc(ptr_q) : ptr_q;
   end

   // Pointer register, cleared to address 0 on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a 16x16 dual-port SRAM.
// Port A is write-only (push side), port B is read-only (pop side). The SRAM
// read is registered and holds its output while disabled, so the presented
// word is the SRAM output itself and only m_valid is tracked here.
// Optional build macro SRAM_FIFO_STATS_EN adds max_level and ovf_attempt.
module sram_fifo_ctrl
   import sram_fifo_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   sram_fifo_ctrl_if.slave   bus,
   output logic [CNT_W-1:0]  count,
   output logic              almost_full,
   output logic              sram_we_a,
   output logic              sram_en_a,
   output logic [ADDR_W-1:0] sram_addr_a,
   output logic [DATA_W-1:0] sram_din_a,
   output logic              sram_we_b,
   output logic              sram_en_b,
   output logic [ADDR_W-1:0] sram_addr_b,
   output logic [DATA_W-1:0] sram_din_b,
   input  logic [DATA_W-1:0] sram_dout_b
`ifdef SRAM_FIFO_STATS_EN
   ,
   output logic [CNT_W-1:0]  max_level,
   output logic              ovf_attempt
`endif
);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;   // words in SRAM not yet fetched
   logic [CNT_W-1:0]  count_q, count_d;       // ram_cnt + presented word
   logic              m_valid_q, m_valid_d;
   logic              s_ready;
   logic              push, pop, fetch;

   // Ready comes from the registered count only, so a full FIFO refuses a
   // push even in a cycle where a pop frees a slot.
   assign s_ready = (count_q < CNT_W'(DEPTH));
   assign push    = bus.s_valid & s_ready;
   assign pop     = m_valid_q & bus.m_ready;
   // Fetch only words already committed on an earlier edge, so port A and
   // port B never address the same entry in one cycle.
   assign fetch   = (ram_cnt_q != '0) & (~m_valid_q | bus.m_ready);

   sram_fifo_ptr u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (push),
      .ptr_o (wr_ptr)
   );

   sram_fifo_ptr u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (fetch),
      .ptr_o (rd_ptr)
   );

   // Next-state for occupancy counters and the output-valid flag.
   always_comb begin
      ram_cnt_d = ram_cnt_q;
      count_d   = count_q;
      m_valid_d = m_valid_q;
      case ({push, fetch})
         2'b10:   ram_cnt_d = ram_cnt_q + CNT_W'(1);
         2'b01:   ram_cnt_d = ram_cnt_q - CNT_W'(1);
         default: ram_cnt_d = ram_cnt_q;
      endcase
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (fetch)    m_valid_d = 1'b1;
      else if (pop) m_valid_d = 1'b0;
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_cnt_q <= '0;
         count_q   <= '0;
         m_valid_q <= 1'b0;
      end else begin
         ram_cnt_q <= ram_cnt_d;
         count_q   <= count_d;
         m_valid_q <= m_valid_d;
      end
   end

   assign bus.s_ready  = s_ready;
   assign bus.m_valid  = m_valid_q;
   assign bus.m_data   = sram_dout_b;
   assign count        = count_q;
   assign almost_full  = (count_q >= CNT_W'(AFULL_THRESH));

   assign sram_we_a    = push;
   assign sram_en_a    = 1'b0;
   assign sram_addr_a  = wr_ptr;
   assign sram_din_a   = bus.s_data;
   assign sram_we_b    = 1'b0;
   assign sram_en_b    = fetch;
   assign sram_addr_b  = rd_ptr;
   assign sram_din_b   = '0;

`ifdef SRAM_FIFO_STATS_EN
   logic [CNT_W-1:0] max_level_q, max_level_d;
   logic             ovf_q, ovf_d;

   // High-water mark follows the new count; overflow flag is sticky.
   always_comb begin
      max_level_d = (count_d > max_level_q) ? count_d : max_level_q;
      ovf_d       = ovf_q | (bus.s_valid & ~s_ready);
   end

   // Statistics registers, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_level_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         max_level_q <= max_level_d;
         ovf_q       <= ovf_d;
      end
   end

   assign max_level   = max_level_q;
   assign ovf_attempt = ovf_q;
`else
   // Statistics outputs are not built.
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a behavioural SRAM and a queue-based reference.
module tb_sram_fifo_ctrl;
   import sram_fifo_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   sram_fifo_ctrl_if bus ();

   logic [CNT_W-1:0]  count;
   logic              almost_full;
   logic              sram_we_a, sram_en_a, sram_we_b, sram_en_b;
   logic [ADDR_W-1:0] sram_addr_a, sram_addr_b;
   logic [DATA_W-1:0] sram_din_a, sram_din_b, sram_dout_b;
`ifdef SRAM_FIFO_STATS_EN
   logic [CNT_W-1:0]  max_level;
   logic              ovf_attempt;
`endif

   sram_fifo_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .count       (count),
      .almost_full (almost_full),
      .sram_we_a   (sram_we_a),
      .sram_en_a   (sram_en_a),
      .sram_addr_a (sram_addr_a),
      .sram_din_a  (sram_din_a),
      .sram_we_b   (sram_we_b),
      .sram_en_b   (sram_en_b),
      .sram_addr_b (sram_addr_b),
      .sram_din_b  (sram_din_b),
      .sram_dout_b (sram_dout_b)
`ifdef SRAM_FIFO_STATS_EN
      ,
      .max_level   (max_level),
      .ovf_attempt (ovf_attempt)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Behavioural SRAM: registered port-B read that holds while disabled.
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (sram_we_a) mem[sram_addr_a] <= sram_din_a;
      if (sram_en_b) sram_dout_b <= mem[sram_addr_b];
   end

   // ---------------- scoreboard state ----------------
   int                n_cmp  = 0;
   int                n_fail = 0;
   logic [DATA_W-1:0] exp_q[$];
   int                wr_n, rd_n;        // words pushed / popped since reset
   int                max_model;
   bit                ovf_model;
   logic              got_pop;
   logic [DATA_W-1:0] pop_data;
   logic              obs_we_a, obs_en_b, obs_mvalid;
   logic [ADDR_W-1:0] obs_addr_a, obs_addr_b;
   logic [DATA_W-1:0] obs_data;
   logic [CNT_W-1:0]  obs_count;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, sample 1 ns later, check
   // against the reference queue, then update the reference.
   task automatic cycle(input logic sv, input logic [DATA_W-1:0] sd, input logic mr);
      int   sz;
      logic do_push, do_pop;
      @(negedge clk);
      bus.s_valid = sv;
      bus.s_data  = sd;
      bus.m_ready = mr;
      #1;
      sz         = exp_q.size();
      obs_we_a   = sram_we_a;
      obs_addr_a = sram_addr_a;
      obs_en_b   = sram_en_b;
      obs_addr_b = sram_addr_b;
      obs_mvalid = bus.m_valid;
      obs_data   = bus.m_data;
      obs_count  = count;
      got_pop    = 1'b0;
      chk("count", 32'(count), 32'(sz));
      chk("s_ready", 32'(bus.s_ready), 32'(sz < DEPTH));
      chk("almost_full", 32'(almost_full), 32'(sz >= AFULL_THRESH));
      chk("din_a", 32'(sram_din_a), 32'(sd));
      chk("tied_offs", 32'({sram_en_a, sram_we_b, sram_din_b}), 32'(0));
      do_push = sv && (sz < DEPTH);
      chk("we_a", 32'(sram_we_a), 32'(do_push));
      if (do_push) chk("addr_a", 32'(sram_addr_a), 32'(wr_n % DEPTH));
      // A read is issued whenever a stored word is not yet presented and the
      // output slot is free or being freed.
      chk("en_b", 32'(sram_en_b), 32'((sz > int'(bus.m_valid)) && (!bus.m_valid || mr)));
      if (sram_en_b) chk("addr_b", 32'(sram_addr_b), 32'((rd_n + int'(bus.m_valid)) % DEPTH));
      if (sz == 0) chk("m_valid_empty", 32'(bus.m_valid), 32'(0));
      do_pop = bus.m_valid && mr && (sz != 0);
      if (do_pop) begin
         pop_data = exp_q.pop_front();
         chk("m_data", 32'(bus.m_data), 32'(pop_data));
         got_pop = 1'b1;
         rd_n++;
      end
      if (do_push) begin
         exp_q.push_back(sd);
         wr_n++;
      end
`ifdef SRAM_FIFO_STATS_EN
      if (sz > max_model) max_model = sz;
      chk("max_level", 32'(max_level), 32'(max_model));
      chk("ovf_attempt", 32'(ovf_attempt), 32'(ovf_model));
      if (sv && sz >= DEPTH) ovf_model = 1'b1;
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_s_ready", 32'(bus.s_ready), 32'(1));
      chk("rst_m_valid", 32'(bus.m_valid), 32'(0));
`ifdef SRAM_FIFO_STATS_EN
      chk("rst_max_level", 32'(max_level), 32'(0));
      chk("rst_ovf", 32'(ovf_attempt), 32'(0));
`endif
      exp_q.delete();
      wr_n = 0; rd_n = 0; max_model = 0; ovf_model = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Watchdog: the stimulus below is bounded, this only guards against a hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, r0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;

      // 1: single word latency
      do_reset();
      cycle(1'b1, 16'h1111, 1'b1);
      chk("t1_we_a", 32'(obs_we_a), 32'(1));
      chk("t1_addr_a", 32'(obs_addr_a), 32'(0));
      cycle(1'b0, 16'h0, 1'b1);
      chk("t1_en_b", 32'(obs_en_b), 32'(1));
      chk("t1_addr_b", 32'(obs_addr_b), 32'(0));
      chk("t1_m_valid_c1", 32'(obs_mvalid), 32'(0));
      cycle(1'b0, 16'h0, 1'b1);
      chk("t1_m_valid_c2", 32'(obs_mvalid), 32'(1));
      chk("t1_m_data_c2", 32'(obs_data), 32'(16'h1111));
      cycle(1'b0, 16'h0, 1'b1);
      chk("t1_count_c3", 32'(obs_count), 32'(0));

      // 2: fill to full, then an ignored 17th write
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(i), 1'b0);
      cycle(1'b1, 16'h00AA, 1'b0);
      chk("t2_count_full", 32'(obs_count), 32'(16));
      chk("t2_s_ready", 32'(bus.s_ready), 32'(0));
      chk("t2_almost_full", 32'(almost_full), 32'(1));
      chk("t2_we_a_17th", 32'(obs_we_a), 32'(0));
      chk("t2_wr_ptr", 32'(obs_addr_a), 32'(0));

      // 3: streaming from full for 40 cycles
      w0 = wr_n; r0 = rd_n;
      for (int i = 0; i < 40; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b1);
      chk("t3_pops", 32'(rd_n - r0), 32'(40));
      chk("t3_pushes", 32'(wr_n - w0), 32'(39));

      // 4: output stall holds data and stops reads
      cycle(1'b0, 16'h0, 1'b0);
      chk("t4_m_valid", 32'(obs_mvalid), 32'(1));
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 16'h0, 1'b0);
         chk("t4_m_data_hold", 32'(obs_data), 32'(exp_q[0]));
         chk("t4_en_b_off", 32'(obs_en_b), 32'(0));
      end

      // 5: asynchronous reset with 7 words held
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() <= 7) break;
         cycle(1'b0, 16'h0, 1'b1);
      end
      @(negedge clk);
      bus.m_ready = 1'b0;
      chk("t5_pre_count", 32'(count), 32'(7));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_s_ready", 32'(bus.s_ready), 32'(1));
      chk("t5_async_m_valid", 32'(bus.m_valid), 32'(0));
      chk("t5_async_count", 32'(count), 32'(0));
      exp_q.delete();
      wr_n = 0; rd_n = 0; max_model = 0; ovf_model = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 16'hBEEF, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 16'($urandom), 1'b1);
         if (got_pop) break;
      end
      chk("t5_popped", 32'(got_pop), 32'(1));
      if (got_pop) chk("t5_first_word", 32'(pop_data), 32'(16'hBEEF));

      // Randomized traffic against the reference queue
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0));
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0) break;
         cycle(1'b0, 16'h0, 1'b1);
      end
      cycle(1'b0, 16'h0, 1'b1);
      chk("drain_empty_count", 32'(obs_count), 32'(0));
      chk("drain_queue", 32'(exp_q.size()), 32'(0));

`ifdef SRAM_FIFO_STATS_EN
      // 6: high-water mark and sticky overflow flag
      do_reset();
      for (int i = 0; i < 9; i++) cycle(1'b1, 16'($urandom), 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         cycle(1'b0, 16'h0, 1'b1);
      end
      cycle(1'b0, 16'h0, 1'b0);
      chk("t6_max_level_9", 32'(max_level), 32'(9));
      chk("t6_ovf_clear", 32'(ovf_attempt), 32'(0));
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'($urandom), 1'b0);
      cycle(1'b1, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      chk("t6_ovf_set", 32'(ovf_attempt), 32'(1));
      for (int i = 0; i < 25; i++) cycle(1'b0, 16'h0, 1'b1);
      chk("t6_ovf_sticky", 32'(ovf_attempt), 32'(1));
      do_reset();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
Controller that turns the 16x16 dual-port SRAM macro into a first-word-fall-through FIFO.
- Upstream side: valid/ready write stream, driving SRAM port A (write-only).
- Downstream side: valid/ready read stream, driving SRAM port B (read-only).
- Sits between a packet producer and the SRAM.
- Accounts for the SRAM's 1-cycle registered read and its hold-when-disabled output behaviour.

Parameters:
- DATA_W, 16, data word width; matches the SRAM.
- ADDR_W, 4, SRAM address width.
- DEPTH, 16, usable entries; must equal 2**ADDR_W.
- AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  write request.
- s_ready  out  1  FIFO can accept a word.
- s_data  in  DATA_W  write data.
- m_valid  out  1  read data available.
- m_ready  in  1  consumer accepts the word.
- m_data  out  DATA_W  read data; combinationally equal to sram_dout_b.
- count  out  ADDR_W+1  total words held, 0..DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- sram_we_a  out  1  to SRAM port A write enable.
- sram_en_a  out  1  to SRAM port A read enable; tied 0.
- sram_addr_a  out  ADDR_W  write pointer.
- sram_din_a  out  DATA_W  equals s_data.
- sram_we_b  out  1  to SRAM port B write enable; tied 0.
- sram_en_b  out  1  to SRAM port B read enable.
- sram_addr_b  out  ADDR_W  read pointer.
- sram_din_b  out  DATA_W  tied 0.
- sram_dout_b  in  DATA_W  SRAM port B registered output.

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous, active-low. rst_n low clears wr_ptr, rd_ptr, ram_cnt, m_valid and count to 0; s_ready is 1 after reset.
- Reset mid-operation discards all content. SRAM array contents and sram_dout_b are not cleared, but m_valid stays 0 until a new write has propagated.
- Push: push = s_valid & s_ready. Same cycle: sram_we_a = 1, sram_addr_a = wr_ptr. At the clock edge, wr_ptr increments and wraps DEPTH-1 -> 0.
- s_ready = (count < DEPTH). It is registered-path only and has no dependence on m_ready: a full FIFO refuses a push even while a pop occurs.
- Internal ram_cnt: words in SRAM not yet read out (0..DEPTH).
- Fetch: fetch = (ram_cnt != 0) & (!m_valid | m_ready). Same cycle: sram_en_b = 1, sram_addr_b = rd_ptr. At the edge, rd_ptr increments with wrap, and m_valid <= 1.
- If no fetch and m_ready & m_valid, then m_valid <= 0.
- sram_dout_b holds its value while sram_en_b = 0, so m_data is stable while m_valid & !m_ready.
- Latency: a word pushed in cycle N is fetched in N+1 and presented (m_valid = 1) in N+2. With continuous flow, throughput is 1 word/cycle.
- Fetch uses only words written on an earlier edge, so port A and port B never collide on one address in the same cycle.
- count = ram_cnt + m_valid, updated each edge: +1 on push, -1 on pop (m_valid & m_ready), unchanged when both occur.
- ram_cnt: +1 on push, -1 on fetch.
- Boundaries:
  - Empty (count 0): m_valid = 0, sram_en_b = 0.
  - Full (count DEPTH): s_ready = 0.
  - Pointers wrap silently; full and empty are derived from the counters, not from pointer compare.

Optional Feature:
SRAM_FIFO_STATS_EN.
- Defined: adds output port max_level (ADDR_W+1 bits) and output port ovf_attempt (1 bit).
  - max_level is the high-water mark of count; cleared by rst_n.
  - ovf_attempt is sticky: it sets when s_valid & !s_ready and clears only on reset.
- Undefined: both ports and their logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package sram_fifo_pkg holds DATA_W, ADDR_W and DEPTH localparams, plus a function for the pointer-increment-with-wrap.
- One sub-module, sram_fifo_ptr: a wrapping ADDR_W pointer with increment enable and async active-low reset. It is instantiated twice (write pointer, read pointer).
- The SRAM itself is instantiated by the parent, not inside this block.

Test Plan:
1. Reset, then push 0x1111 in cycle 0 with m_ready = 1 -> sram_we_a = 1 at addr 0 in cycle 0; sram_en_b = 1 at addr 0 in cycle 1; m_valid = 1 and m_data = 0x1111 in cycle 2; count returns to 0 in cycle 3.
2. Push 16 words 0x0000..0x000F with m_ready = 0 -> s_ready = 0 after the 16th push; count = 16; almost_full = 1 from count 12. A 17th s_valid is ignored and wr_ptr stays 0.
3. From full, hold s_valid = 1 and m_ready = 1 for 40 cycles with an incrementing pattern -> output is strictly in order with no loss or duplicates; pointers wrap at least twice.
4. Hold m_ready = 0 for 5 cycles while m_valid = 1 -> m_data is constant and sram_en_b = 0 throughout.
5. Pulse rst_n low mid-stream with count = 7 -> s_ready = 1 and m_valid = 0 immediately (asynchronously) and count = 0. The next push 0xBEEF is read out first.
6. With SRAM_FIFO_STATS_EN defined, reach count 9 then drain, then drive s_valid while full -> max_level = 9, and ovf_attempt = 1 stays set until reset.
